// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA raster generator: default 640x480@60 segment
// lengths, derived totals, pipeline payload type and 12-bit rgb field slices.
package vga_timing_pkg;

  localparam int H_VIS_DEF  = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;
  localparam int V_VIS_DEF  = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;

  localparam int H_TOTAL_DEF = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int R_MSB = 11;
  localparam int R_LSB = 8;
  localparam int G_MSB = 7;
  localparam int G_LSB = 4;
  localparam int B_MSB = 3;
  localparam int B_LSB = 0;

  typedef struct packed {
    logic [11:0] rgb;
    logic        bright;
    logic        hs;
    logic        vs;
  } pix_t;

  // Idle pin state: syncs deasserted (high), nothing visible.
  localparam pix_t PIX_RST = '{rgb: 12'h000, bright: 1'b0, hs: 1'b1, vs: 1'b1};

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-coordinate bus between the raster source and sprite controllers,
// plus the VGA pin bundle driven by the source.
interface vga_timing_gen_if;
  logic [9:0]  hc;
  logic [9:0]  vc;
  logic        bright;
  logic        pix_en;
  logic        line_end;
  logic        frame_end;
  logic [15:0] frame_cnt;
  logic [11:0] rgb_in;
  logic        hSync;
  logic        vSync;
  logic [3:0]  vgaR;
  logic [3:0]  vgaG;
  logic [3:0]  vgaB;

  modport master (
    output hc, vc, bright, pix_en, line_end, frame_end, frame_cnt,
    output hSync, vSync, vgaR, vgaG, vgaB,
    input  rgb_in
  );

  modport slave (
    input  hc, vc, bright, pix_en, line_end, frame_end, frame_cnt,
    input  hSync, vSync, vgaR, vgaG, vgaB,
    output rgb_in
  );
endinterface

// File: rtl/vga_out_pipe.sv
// Pixel-rate output delay line; colour and syncs travel together so they
// stay aligned, and blanking is applied after the last stage.
module vga_out_pipe
  import vga_timing_pkg::*;
#(
  parameter int PIPE_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  pix_t       pix_in,
  output logic       hSync,
  output logic       vSync,
  output logic [3:0] vgaR,
  output logic [3:0] vgaG,
  output logic [3:0] vgaB
);

  pix_t        stg [PIPE_DEPTH];
  logic [11:0] col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < PIPE_DEPTH; k++) stg[k] <= PIX_RST;
    end else if (pix_en) begin
      stg[0] <= pix_in;
      for (int k = 1; k < PIPE_DEPTH; k++) stg[k] <= stg[k-1];
    end
  end

  assign col   = stg[PIPE_DEPTH-1].bright ? stg[PIPE_DEPTH-1].rgb : 12'h000;
  assign hSync = stg[PIPE_DEPTH-1].hs;
  assign vSync = stg[PIPE_DEPTH-1].vs;
  assign vgaR  = col[R_MSB:R_LSB];
  assign vgaG  = col[G_MSB:G_LSB];
  assign vgaB  = col[B_MSB:B_LSB];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel-rate divider, hc/vc counters, sync decode and
// strobes, feeding the delay-matched VGA pin pipeline.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int H_VIS      = H_VIS_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_VIS      = V_VIS_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int PIPE_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_timing_gen_if.master  vif
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(CLK_DIV);

  logic [DW-1:0] div_q;
  logic [9:0]    hc_q;
  logic [9:0]    vc_q;
  logic [15:0]   frame_cnt_q;
  logic          pix_en;
  logic          h_last;
  logic          v_last;
  logic          line_end;
  logic          frame_end;
  logic          bright;
  logic          hs_raw;
  logic          vs_raw;
  pix_t          pix_raw;

  assign pix_en    = (div_q == DW'(CLK_DIV - 1));
  assign h_last    = (hc_q == 10'(H_TOTAL - 1));
  assign v_last    = (vc_q == 10'(V_TOTAL - 1));
  assign line_end  = pix_en && h_last;
  assign frame_end = line_end && v_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      div_q <= '0;
    else if (pix_en) div_q <= '0;
    else             div_q <= div_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q <= '0;
      vc_q <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        hc_q <= '0;
        vc_q <= v_last ? '0 : vc_q + 1'b1;
      end else begin
        hc_q <= hc_q + 1'b1;
      end
    end
  end

  // Only written on frame_end so the count holds between frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         frame_cnt_q <= '0;
    else if (frame_end) frame_cnt_q <= frame_cnt_q + 1'b1;
  end

  assign bright = (hc_q < 10'(H_VIS)) && (vc_q < 10'(V_VIS));
  assign hs_raw = !((hc_q >= 10'(H_VIS + H_FP)) && (hc_q < 10'(H_VIS + H_FP + H_SYNC)));
  assign vs_raw = !((vc_q >= 10'(V_VIS + V_FP)) && (vc_q < 10'(V_VIS + V_FP + V_SYNC)));

  assign pix_raw = '{rgb: vif.rgb_in, bright: bright, hs: hs_raw, vs: vs_raw};

  vga_out_pipe #(.PIPE_DEPTH(PIPE_DEPTH)) u_out_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_en (pix_en),
    .pix_in (pix_raw),
    .hSync  (vif.hSync),
    .vSync  (vif.vSync),
    .vgaR   (vif.vgaR),
    .vgaG   (vif.vgaG),
    .vgaB   (vif.vgaB)
  );

  assign vif.hc        = hc_q;
  assign vif.vc        = vc_q;
  assign vif.bright    = bright;
  assign vif.pix_en    = pix_en;
  assign vif.line_end  = line_end;
  assign vif.frame_end = frame_end;
  assign vif.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Checks the raster source against a pixel-index model: every observable is
// derived from the number of clocks since reset release.
module tb_vga_timing_gen;

  localparam int D   = 3;
  localparam int HV  = 20, HF = 3, HS = 4, HB = 5;
  localparam int VV  = 10, VF = 2, VS = 2, VB = 3;
  localparam int PD  = 2;
  localparam int HT  = HV + HF + HS + HB;
  localparam int VT  = VV + VF + VS + VB;
  localparam int FRM = HT * VT;
  localparam int NH  = 4096;

  logic clk;
  logic rst_n;
  int   e;
  int   fc_base;
  int   n_chk;
  int   n_fail;
  int   n_line;
  int   n_frame;
  logic [11:0] hist [NH];

  vga_timing_gen_if vif ();

  vga_timing_gen #(
    .CLK_DIV(D), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .PIPE_DEPTH(PD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vif   (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (clk %0d after release)", tag, got, exp, e);
    end
  endtask

  task automatic fill_hist();
    for (int i = 0; i < NH; i++) hist[i] = 12'($urandom);
    hist[3*HT + 5]  = 12'hF0A;   // visible pixel, must reach the pins
    hist[3*HT + 25] = 12'hFFF;   // blanking interval, must be suppressed
  endtask

  // Expected state after e clock edges since release.
  task automatic check_all();
    int p, ph, q, qh, qv, ehc, evc;
    logic epe, ele, efe, ebr, ehs, evs;
    logic [11:0] ecol;
    p   = e / D;
    ph  = e % D;
    ehc = p % HT;
    evc = (p / HT) % VT;
    epe = (ph == D - 1);
    ele = epe && (ehc == HT - 1);
    efe = ele && (evc == VT - 1);
    ebr = (ehc < HV) && (evc < VV);
    if (p >= PD) begin
      q    = p - PD;
      qh   = q % HT;
      qv   = (q / HT) % VT;
      ehs  = !(qh >= HV + HF && qh < HV + HF + HS);
      evs  = !(qv >= VV + VF && qv < VV + VF + VS);
      ecol = (qh < HV && qv < VV) ? hist[q % NH] : 12'h000;
    end else begin
      ehs  = 1'b1;
      evs  = 1'b1;
      ecol = 12'h000;
    end
    chk("pix_en",    32'(vif.pix_en),    32'(epe));
    chk("line_end",  32'(vif.line_end),  32'(ele));
    chk("frame_end", 32'(vif.frame_end), 32'(efe));
    chk("hc",        32'(vif.hc),        32'(ehc));
    chk("vc",        32'(vif.vc),        32'(evc));
    chk("bright",    32'(vif.bright),    32'(ebr));
    chk("frame_cnt", 32'(vif.frame_cnt), 32'((fc_base + p / FRM) & 16'hFFFF));
    chk("hSync",     32'(vif.hSync),     32'(ehs));
    chk("vSync",     32'(vif.vSync),     32'(evs));
    chk("colour",    32'({vif.vgaR, vif.vgaG, vif.vgaB}), 32'(ecol));
    if (vif.line_end === 1'b1)  n_line++;
    if (vif.frame_end === 1'b1) n_frame++;
  endtask

  task automatic step();
    @(posedge clk);
    e++;
    @(negedge clk);
    check_all();
    vif.rgb_in = hist[(e / D) % NH];
  endtask

  task automatic release_rst();
    @(negedge clk);
    fill_hist();
    e       = 0;
    fc_base = 0;
    n_line  = 0;
    n_frame = 0;
    vif.rgb_in = hist[0];
    rst_n = 1'b1;
    #1;
    check_all();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hc"},     32'(vif.hc),        32'd0);
    chk({tag, "_vc"},     32'(vif.vc),        32'd0);
    chk({tag, "_pix_en"}, 32'(vif.pix_en),    32'd0);
    chk({tag, "_lend"},   32'(vif.line_end),  32'd0);
    chk({tag, "_fend"},   32'(vif.frame_end), 32'd0);
    chk({tag, "_fcnt"},   32'(vif.frame_cnt), 32'd0);
    chk({tag, "_hsync"},  32'(vif.hSync),     32'd1);
    chk({tag, "_vsync"},  32'(vif.vSync),     32'd1);
    chk({tag, "_col"},    32'({vif.vgaR, vif.vgaG, vif.vgaB}), 32'd0);
  endtask

  localparam int P_A = 2*FRM + 5*HT + 26;   // stop where delayed hSync is low
  localparam int P_F = 100;
  localparam int P_B = FRM + 40;

  initial begin
    n_chk = 0; n_fail = 0; e = 0; fc_base = 0; n_line = 0; n_frame = 0;
    rst_n = 1'b1;
    vif.rgb_in = 12'h000;
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("por");

    // Run A: two full frames plus part of a third.
    release_rst();
    repeat (P_A * D) step();
    chk("lines_a",  32'(n_line),  32'(P_A / HT));
    chk("frames_a", 32'(n_frame), 32'(P_A / FRM));
    chk("hsync_pre_rst", 32'(vif.hSync), 32'd0);

    // Mid-frame asynchronous reset, checked before any clock edge.
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("mid");
    chk("mid_bright", 32'(vif.bright), 32'd1);
    repeat (5) @(negedge clk);
    chk_reset_vals("hold");

    // Run B: restart at (0,0); jam the frame counter to exercise its wrap.
    release_rst();
    repeat (P_F * D) step();
    force dut.frame_cnt_q = 16'hFFFF;
    #1 release dut.frame_cnt_q;
    fc_base = 16'hFFFF;
    chk("fcnt_forced", 32'(vif.frame_cnt), 32'h0000FFFF);
    repeat ((P_B - P_F) * D) step();
    chk("fcnt_wrap",  32'(vif.frame_cnt), 32'd0);
    chk("frames_b",   32'(n_frame),       32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
